// File: rtl/sys_ctrl_tx_serializer.sv
// TX path serializer: queues one register-file read and one ALU result, then
// streams them as FIFO_WIDTH-bit words into the UART TX FIFO write port.
module sys_ctrl_tx_serializer #(
    parameter int unsigned FIFO_WIDTH    = 8,
    parameter int unsigned ALU_OUT_WIDTH = 16,
    parameter bit          MSB_FIRST     = 1'b0
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [FIFO_WIDTH-1:0]    Rd_data,
    input  logic                     Rd_data_valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_valid,
    input  logic                     Full,
    input  logic                     Wr_Ack,
    input  logic                     Ovf_clr,
    output logic [FIFO_WIDTH-1:0]    FIFO_IN,
    output logic                     Wr_Req,
    output logic                     Busy,
    output logic                     Overflow
);

    localparam int unsigned NUM_WORDS = ALU_OUT_WIDTH / FIFO_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int unsigned RD_SHIFT  = ALU_OUT_WIDTH - FIFO_WIDTH;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                   state_q, state_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [FIFO_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                     alu_pend_q, alu_pend_d;
    logic [ALU_OUT_WIDTH-1:0] alu_data_q, alu_data_d;
    logic [ALU_OUT_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FIFO_WIDTH-1:0]    fifo_in_q, fifo_in_d;
    logic                     ovf_q, ovf_d;

    logic                     load_rd, load_alu, accept, last_word;
    logic                     rd_ovf, alu_ovf;
    logic [ALU_OUT_WIDTH-1:0] rd_ext, rd_load, shift_nxt;

    // The word currently on the wire sits at the end the shift moves toward.
    function automatic logic [FIFO_WIDTH-1:0] cur_word(input logic [ALU_OUT_WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[ALU_OUT_WIDTH-1 -: FIFO_WIDTH];
        end
        return v[FIFO_WIDTH-1:0];
    endfunction

    assign load_rd   = (state_q == StIdle) && rd_pend_q;
    assign load_alu  = (state_q == StIdle) && !rd_pend_q && alu_pend_q;
    assign accept    = Wr_Req && Wr_Ack;
    assign last_word = (cnt_q == CNT_W'(1));

    assign rd_ext    = ALU_OUT_WIDTH'(rd_data_q);
    assign rd_load   = MSB_FIRST ? (rd_ext << RD_SHIFT) : rd_ext;
    assign shift_nxt = MSB_FIRST ? (shift_q << FIFO_WIDTH) : (shift_q >> FIFO_WIDTH);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= '0;
            alu_pend_q <= 1'b0;
            alu_data_q <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            fifo_in_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_data_q  <= rd_data_d;
            alu_pend_q <= alu_pend_d;
            alu_data_q <= alu_data_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            fifo_in_q  <= fifo_in_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (rd_pend_q || alu_pend_q) state_d = StSend;
            StSend: if (accept && last_word) state_d = StIdle;
        endcase
    end

    always_comb begin
        Wr_Req   = (state_q == StSend) && !Full;
        Busy     = (state_q == StSend) || rd_pend_q || alu_pend_q;
        FIFO_IN  = fifo_in_q;
        Overflow = ovf_q;
    end

    // A strobe into an occupied slot is dropped unless the slot drains this cycle.
    always_comb begin
        rd_ovf     = Rd_data_valid && rd_pend_q && !load_rd;
        alu_ovf    = ALU_OUT_valid && alu_pend_q && !load_alu;
        rd_pend_d  = rd_pend_q;
        rd_data_d  = rd_data_q;
        alu_pend_d = alu_pend_q;
        alu_data_d = alu_data_q;

        if (Rd_data_valid && !rd_ovf) begin
            rd_pend_d = 1'b1;
            rd_data_d = Rd_data;
        end else if (load_rd) begin
            rd_pend_d = 1'b0;
        end

        if (ALU_OUT_valid && !alu_ovf) begin
            alu_pend_d = 1'b1;
            alu_data_d = ALU_OUT;
        end else if (load_alu) begin
            alu_pend_d = 1'b0;
        end

        if (rd_ovf || alu_ovf) begin
            ovf_d = 1'b1;
        end else if (Ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        fifo_in_d = fifo_in_q;
        if (load_rd) begin
            shift_d   = rd_load;
            cnt_d     = CNT_W'(1);
            fifo_in_d = rd_data_q;
        end else if (load_alu) begin
            shift_d   = alu_data_q;
            cnt_d     = CNT_W'(NUM_WORDS);
            fifo_in_d = cur_word(alu_data_q);
        end else if (accept) begin
            if (last_word) begin
                cnt_d = '0;
            end else begin
                shift_d   = shift_nxt;
                cnt_d     = cnt_q - CNT_W'(1);
                fifo_in_d = cur_word(shift_nxt);
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_tx_serializer.sv
// Scoreboard bench: two serializer instances (16-bit LSB-first, 32-bit MSB-first)
// share stimulus; a frame-level model predicts words, handshakes and flags.
module tb_sys_ctrl_tx_serializer;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  Rd_data = '0;
    logic        Rd_data_valid = 1'b0;
    logic [31:0] alu_in = '0;
    logic        ALU_OUT_valid = 1'b0;
    logic        Full = 1'b0;
    logic        Wr_Ack = 1'b1;
    logic        Ovf_clr = 1'b0;

    logic [7:0]  fifo_a, fifo_b;
    logic        wr_a, wr_b, busy_a, busy_b, ovf_a, ovf_b;

    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 CLK = ~CLK;

    sys_ctrl_tx_serializer #(.FIFO_WIDTH(8), .ALU_OUT_WIDTH(16), .MSB_FIRST(1'b0)) u_dut_a (
        .CLK(CLK), .rst(rst), .Rd_data(Rd_data), .Rd_data_valid(Rd_data_valid),
        .ALU_OUT(alu_in[15:0]), .ALU_OUT_valid(ALU_OUT_valid), .Full(Full), .Wr_Ack(Wr_Ack),
        .Ovf_clr(Ovf_clr), .FIFO_IN(fifo_a), .Wr_Req(wr_a), .Busy(busy_a), .Overflow(ovf_a)
    );

    sys_ctrl_tx_serializer #(.FIFO_WIDTH(8), .ALU_OUT_WIDTH(32), .MSB_FIRST(1'b1)) u_dut_b (
        .CLK(CLK), .rst(rst), .Rd_data(Rd_data), .Rd_data_valid(Rd_data_valid),
        .ALU_OUT(alu_in), .ALU_OUT_valid(ALU_OUT_valid), .Full(Full), .Wr_Ack(Wr_Ack),
        .Ovf_clr(Ovf_clr), .FIFO_IN(fifo_b), .Wr_Req(wr_b), .Busy(busy_b), .Overflow(ovf_b)
    );

    // Model state, index 0 = instance a, 1 = instance b.
    bit          m_send[2];
    int          m_rem[2];
    bit          m_rd_p[2];
    logic [7:0]  m_rd_v[2];
    bit          m_alu_p[2];
    logic [31:0] m_alu_v[2];
    bit          m_ovf[2];
    logic [7:0]  m_last[2];
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    function automatic int words_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    // Word i of an ALU frame, in transmission order.
    function automatic logic [7:0] alu_word(int d, logic [31:0] v, int i);
        int idx;
        idx = (d == 1) ? (words_of(d) - 1 - i) : i;
        return 8'(v >> (8 * idx));
    endfunction

    task automatic push_exp(int d, logic [7:0] w);
        if (d == 0) exp_a.push_back(w);
        else exp_b.push_back(w);
    endtask

    function automatic int exp_size(int d);
        return (d == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic logic [7:0] exp_front(int d);
        return (d == 0) ? exp_a[0] : exp_b[0];
    endfunction

    task automatic exp_pop(int d);
        if (d == 0) void'(exp_a.pop_front());
        else void'(exp_b.pop_front());
    endtask

    task automatic model_step(int d);
        bit          c_rd = 1'b0;
        bit          c_alu = 1'b0;
        bit          ovf_set = 1'b0;
        logic [31:0] v;
        if (rst) begin
            m_send[d] = 0; m_rem[d] = 0; m_rd_p[d] = 0; m_alu_p[d] = 0;
            m_ovf[d] = 0; m_last[d] = 8'h00;
            if (d == 0) exp_a.delete();
            else exp_b.delete();
            return;
        end
        if (!m_send[d]) begin
            if (m_rd_p[d]) begin
                push_exp(d, m_rd_v[d]);
                m_rem[d] = 1; m_send[d] = 1; c_rd = 1;
            end else if (m_alu_p[d]) begin
                for (int i = 0; i < words_of(d); i++) push_exp(d, alu_word(d, m_alu_v[d], i));
                m_rem[d] = words_of(d); m_send[d] = 1; c_alu = 1;
            end
        end else if (!Full && Wr_Ack) begin
            m_rem[d]--;
            if (m_rem[d] == 0) m_send[d] = 0;
        end
        if (Rd_data_valid) begin
            if (m_rd_p[d] && !c_rd) ovf_set = 1;
            else begin m_rd_p[d] = 1; m_rd_v[d] = Rd_data; end
        end else if (c_rd) m_rd_p[d] = 0;
        v = (d == 0) ? {16'h0, alu_in[15:0]} : alu_in;
        if (ALU_OUT_valid) begin
            if (m_alu_p[d] && !c_alu) ovf_set = 1;
            else begin m_alu_p[d] = 1; m_alu_v[d] = v; end
        end else if (c_alu) m_alu_p[d] = 0;
        if (ovf_set) m_ovf[d] = 1;
        else if (Ovf_clr) m_ovf[d] = 0;
    endtask

    initial forever begin
        @(posedge CLK);
        for (int d = 0; d < 2; d++) model_step(d);
    end

    // Monitor: every cycle compare handshake, flags and word against the model.
    initial forever begin
        @(negedge CLK);
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] fi;
                logic       wr, bsy, ov;
                fi  = (d == 0) ? fifo_a : fifo_b;
                wr  = (d == 0) ? wr_a : wr_b;
                bsy = (d == 0) ? busy_a : busy_b;
                ov  = (d == 0) ? ovf_a : ovf_b;
                chk("wr_req", d, 32'(wr), 32'(m_send[d] && !Full));
                chk("busy", d, 32'(bsy), 32'(m_send[d] || m_rd_p[d] || m_alu_p[d]));
                chk("overflow", d, 32'(ov), 32'(m_ovf[d]));
                if (m_send[d]) begin
                    chk("expected_word_available", d, 32'(exp_size(d) > 0), 32'd1);
                    if (exp_size(d) > 0) chk("fifo_in", d, 32'(fi), 32'(exp_front(d)));
                end else begin
                    chk("fifo_in_idle", d, 32'(fi), 32'(m_last[d]));
                end
                if (wr === 1'b1 && Wr_Ack) begin
                    chk("accept_has_word", d, 32'(exp_size(d) > 0), 32'd1);
                    if (exp_size(d) > 0) begin
                        m_last[d] = exp_front(d);
                        exp_pop(d);
                    end
                end
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
            Rd_data_valid = 1'b0;
            ALU_OUT_valid = 1'b0;
            Ovf_clr = 1'b0;
        end
    endtask

    task automatic send_rd(logic [7:0] v);
        Rd_data = v; Rd_data_valid = 1'b1;
    endtask

    task automatic send_alu(logic [31:0] v);
        alu_in = v; ALU_OUT_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        mon_en = 1'b1;
        step(1);

        // Single read word.
        send_rd(8'hA5); step(1); step(5);
        // ALU frame, order depends on instance.
        send_alu(32'h5678_1234); step(1); step(8);
        // Full stall after the first accepted word.
        send_alu(32'hDEAD_BEEF); step(2);
        Full = 1'b1; step(5);
        Full = 1'b0; step(10);
        // Simultaneous read and ALU: read goes first.
        send_rd(8'h11); send_alu(32'h4455_2233); step(1); step(10);
        // Overflow: third ALU strobe while the pend slot is still occupied.
        Full = 1'b1;
        send_alu(32'h0000_0102); step(3);
        send_alu(32'h0000_0304); step(1);
        send_alu(32'h0000_0506); step(1);
        Full = 1'b0; step(14);
        Ovf_clr = 1'b1; step(1); step(2);
        // Reset in the middle of a frame.
        send_alu(32'hCAFE_F00D); step(3);
        rst = 1'b1; step(1);
        rst = 1'b0; step(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            Rd_data       = 8'($urandom);
            Rd_data_valid = ($urandom_range(0, 9) == 0);
            alu_in        = $urandom;
            ALU_OUT_valid = ($urandom_range(0, 11) == 0);
            Full          = ($urandom_range(0, 3) == 0);
            Wr_Ack        = ($urandom_range(0, 4) != 0);
            Ovf_clr       = ($urandom_range(0, 29) == 0);
            rst           = ($urandom_range(0, 599) == 0);
            @(posedge CLK);
            #1;
        end

        // Drain with a bounded budget and confirm both instances went idle.
        rst = 1'b0; Rd_data_valid = 1'b0; ALU_OUT_valid = 1'b0; Ovf_clr = 1'b0;
        Full = 1'b0; Wr_Ack = 1'b1;
        step(40);
        @(negedge CLK);
        chk("drain_busy", 0, 32'(busy_a), 32'd0);
        chk("drain_busy", 1, 32'(busy_b), 32'd0);
        chk("drain_leftover", 0, 32'(exp_size(0)), 32'd0);
        chk("drain_leftover", 1, 32'(exp_size(1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_tx_serializer.md
Name: sys_ctrl_tx_serializer

Overview:
Parametrised system-controller TX path that turns register-file read data and ALU results of any width into a stream of FIFO_WIDTH-bit words for the UART TX asynchronous FIFO. Each source has a one-deep pending register, so a result arriving while a frame is being sent is queued, not lost. Byte order is selectable. Overrun is reported through a sticky flag. Sits between the register file/ALU and the TX FIFO write port.

Parameters:
FIFO_WIDTH, 8, width of one FIFO word and of Rd_data
ALU_OUT_WIDTH, 16, ALU result width; must be an integer multiple of FIFO_WIDTH
NUM_WORDS, ALU_OUT_WIDTH/FIFO_WIDTH (derived, localparam), words per ALU frame
MSB_FIRST, 0, 0 sends ALU least-significant word first; 1 sends most-significant word first

Ports:
CLK  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
Rd_data  input  FIFO_WIDTH  register-file read data
Rd_data_valid  input  1  single-cycle strobe qualifying Rd_data
ALU_OUT  input  ALU_OUT_WIDTH  ALU result
ALU_OUT_valid  input  1  single-cycle strobe qualifying ALU_OUT
Full  input  1  TX FIFO full
Wr_Ack  input  1  FIFO accepted the current write (same cycle as Wr_Req)
Ovf_clr  input  1  clears Overflow
FIFO_IN  output  FIFO_WIDTH  word presented to the FIFO
Wr_Req  output  1  write request
Busy  output  1  frame in progress or any source pending
Overflow  output  1  sticky: a source strobe arrived while its pending register was occupied

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, FIFO_IN=0, Wr_Req=0, Busy=0, Overflow=0, both pending registers empty, word counter=0, shift register=0. Reset mid-frame abandons the remaining words. No partial flush.
- Pending capture, per source:
  - A strobe loads data into that source's pending register and sets its pend bit.
  - If pend is already set and is not consumed in the same cycle, the new data is dropped, the old data is kept, and Overflow is set.
  - If pend is consumed in the same cycle, the new data is captured and there is no overflow.
- States: IDLE, SEND.
- IDLE:
  - If rd_pend: load the shift register with Rd_data pending, counter=1, clear rd_pend, go to SEND.
  - Else if alu_pend: load the shift register with the ALU pending value, counter=NUM_WORDS, clear alu_pend, go to SEND.
  - Read data always has priority over ALU when both are pending.
- SEND:
  - FIFO_IN = current word: low FIFO_WIDTH bits of the shift register (MSB_FIRST=0) or high bits (MSB_FIRST=1).
  - Wr_Req = !Full (combinational). Wr_Req=0 in IDLE.
  - A word is accepted when Wr_Req && Wr_Ack.
  - On acceptance with counter>1: shift by FIFO_WIDTH toward the current-word end, counter-1, stay in SEND.
  - On acceptance with counter==1: go to IDLE.
  - Without acceptance: hold FIFO_IN and counter. Full stalls indefinitely.
- Latency: a strobe at cycle t (idle, both pends empty, Full=0) gives the first Wr_Req at cycle t+2. Back-to-back frames have one IDLE cycle between the last accept and the next Wr_Req.
- FIFO_IN is registered and changes only on load or accept. Its value in IDLE is the last sent word.
- Busy = (state==SEND) | rd_pend | alu_pend.
- Overflow: set has priority over Ovf_clr in the same cycle.
- Counter width: $clog2(NUM_WORDS+1).
- NUM_WORDS=1 is legal: an ALU frame is then one word.

Test Plan:
1. Reset, then Rd_data=8'hA5 strobe, Full=0, Wr_Ack on request -> Wr_Req high for exactly 1 cycle at t+2 with FIFO_IN=8'hA5. Busy low after.
2. ALU_OUT=16'h1234 strobe, MSB_FIRST=0 -> FIFO_IN 8'h34 then 8'h12, two accepted writes. Repeat with MSB_FIRST=1 -> 8'h12 then 8'h34.
3. ALU_OUT=16'hBEEF, Full=1 for 5 cycles after the first Wr_Req cycle -> Wr_Req=0 while Full. FIFO_IN holds 8'hEF. Sequence resumes EF, BE once Full drops. No word lost.
4. Rd_data_valid and ALU_OUT_valid in the same cycle (8'h11, 16'h2233) -> output order 11, 33, 22. Overflow=0.
5. Two ALU strobes (16'h0102, then 16'h0304) during an in-flight frame with a third (16'h0506) before the pend is consumed -> Overflow=1. 16'h0506 is dropped. Ovf_clr for 1 cycle -> Overflow=0.
6. Assert rst while the second ALU word is pending in SEND (ALU_OUT_WIDTH=32) -> next cycle Wr_Req=0, FIFO_IN=0, Busy=0, Overflow=0. No further writes.
